dht11_poll_scheduler: RTL and testbench

//   Sequences a DHT11 frame reader: periodic or host-requested triggers, sensor min-gap, timeout,

---
 rtl/dht11_poll_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_dht11_poll_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_poll_scheduler.sv
// -----------------------------------------------------------------------------
// dht11_poll_scheduler
//   Decides when a DHT11 frame read happens and what is done with the result.
//   A read is started by the periodic timer or by a host request. The sensor's
//   minimum rest time between reads is respected. Each read attempt has a
//   timeout and a checksum check. A failed attempt is retried after a back-off,
//   up to a bounded number of attempts. The last good humidity and temperature
//   are published together with valid/stale status and an error counter.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        1 = new transactions may be started
//   host_req      on-demand request (level, remembered until served)
//   host_ack      1-cycle pulse when the transaction serving a host request ends
//   sensor_start  1-cycle pulse telling the reader to begin a frame
//   sensor_busy   reader is mid-frame; holds off sensor_start
//   sensor_done   1-cycle pulse, sensor_frame is valid
//   sensor_frame  {RH_int, RH_dec, T_int, T_dec, checksum}
//   humidity      last good RH_int
//   temperature   last good T_int
//   valid         1-cycle pulse when humidity/temperature update
//   stale         set by a failed transaction, cleared by the next success
//   err_cnt       saturating count of failed transactions
// -----------------------------------------------------------------------------
module dht11_poll_scheduler #(
   parameter int unsigned SAMPLE_PERIOD = 50_000_000,
   parameter int unsigned MIN_GAP       = 50_000_000,
   parameter int unsigned TIMEOUT       = 500_000,
   parameter int unsigned RETRY_GAP     = 1_000_000,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        host_req,
   output logic        host_ack,
   output logic        sensor_start,
   input  logic        sensor_busy,
   input  logic        sensor_done,
   input  logic [39:0] sensor_frame,
   output logic [7:0]  humidity,
   output logic [7:0]  temperature,
   output logic        valid,
   output logic        stale,
   output logic [7:0]  err_cnt
);

   localparam int unsigned TMR_MAX = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
   localparam int PW = $clog2(SAMPLE_PERIOD + 1);
   localparam int GW = $clog2(MIN_GAP + 1);
   localparam int TW = $clog2(TMR_MAX + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [GW-1:0] GAP_FULL    = GW'(MIN_GAP);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] BO_LAST     = TW'(RETRY_GAP - 1);
   localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TRIG    = 3'd1,
      S_WAIT    = 3'd2,
      S_CHECK   = 3'd3,
      S_BACKOFF = 3'd4
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   period_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [TW-1:0]   tmr;
   logic [RW-1:0]   retry_cnt;
   logic            req_pend;
   logic            served;
   logic [39:0]     frame;

   logic            trigger;
   logic            att_pass;
   logic            att_fail;
   logic            retry;
   logic            last_try;
   logic            final_fail;
   logic            to_idle;

   // Checksum: byte sum of the four data bytes, modulo 256.
   function automatic logic frame_sum_ok(input logic [39:0] f);
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return (s == f[7:0]);
   endfunction

   assign last_try     = (retry_cnt == RETRY_LAST);
   assign final_fail   = att_fail && last_try;
   assign to_idle      = att_pass || final_fail;
   // Combinational so the pulse lands in the TRIG cycle and follows sensor_busy.
   assign sensor_start = (state == S_TRIG) && !sensor_busy;

   // Next-state decode and per-cycle event strobes.
   always_comb begin
      state_next = state;
      trigger    = 1'b0;
      att_pass   = 1'b0;
      att_fail   = 1'b0;
      retry      = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable && (gap_cnt >= GAP_FULL) &&
                ((period_cnt == PERIOD_LAST) || req_pend)) begin
               trigger    = 1'b1;
               state_next = S_TRIG;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_TRIG: begin
            if (!sensor_busy) begin
               state_next = S_WAIT;
            end else begin
               state_next = S_TRIG;
            end
         end
         S_WAIT: begin
            // A done pulse in the timeout cycle still counts.
            if (sensor_done) begin
               state_next = S_CHECK;
            end else if (tmr == TMO_LAST) begin
               att_fail   = 1'b1;
               state_next = last_try ? S_IDLE : S_BACKOFF;
            end else begin
               state_next = S_WAIT;
            end
         end
         S_CHECK: begin
            if (frame_sum_ok(frame)) begin
               att_pass   = 1'b1;
               state_next = S_IDLE;
            end else begin
               att_fail   = 1'b1;
               state_next = last_try ? S_IDLE : S_BACKOFF;
            end
         end
         S_BACKOFF: begin
            if (tmr == BO_LAST) begin
               retry      = 1'b1;
               state_next = S_TRIG;
            end else begin
               state_next = S_BACKOFF;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Scheduling counters, pending request and captured frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt <= '0;
         gap_cnt    <= GAP_FULL;
         tmr        <= '0;
         retry_cnt  <= '0;
         req_pend   <= 1'b0;
         served     <= 1'b0;
         frame      <= 40'h00_0000_0000;
      end else begin
         if (trigger) begin
            period_cnt <= '0;
         end else if (period_cnt != PERIOD_LAST) begin
            period_cnt <= period_cnt + PW'(1);
         end

         if (to_idle) begin
            gap_cnt <= '0;
         end else if ((state == S_IDLE) && (gap_cnt != GAP_FULL)) begin
            gap_cnt <= gap_cnt + GW'(1);
         end

         // One timer serves both WAIT (timeout) and BACKOFF (retry gap).
         if ((state == S_TRIG) || att_fail) begin
            tmr <= '0;
         end else if ((state == S_WAIT) || (state == S_BACKOFF)) begin
            tmr <= tmr + TW'(1);
         end

         if (trigger) begin
            retry_cnt <= '0;
         end else if (retry) begin
            retry_cnt <= retry_cnt + RW'(1);
         end

         // A request seen in the trigger cycle itself is kept for a later transaction.
         req_pend <= host_req || (req_pend && !trigger);

         if (trigger) begin
            served <= req_pend;
         end else if (to_idle) begin
            served <= 1'b0;
         end

         if ((state == S_WAIT) && sensor_done) begin
            frame <= sensor_frame;
         end
      end
   end

   // Published results and status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         humidity    <= 8'h00;
         temperature <= 8'h00;
         valid       <= 1'b0;
         stale       <= 1'b0;
         err_cnt     <= 8'h00;
         host_ack    <= 1'b0;
      end else begin
         valid    <= att_pass;
         host_ack <= to_idle && served;
         if (att_pass) begin
            humidity    <= frame[39:32];
            temperature <= frame[23:16];
            stale       <= 1'b0;
         end else if (final_fail) begin
            stale <= 1'b1;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'h01;
            end
         end
      end
   end

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dht11_poll_scheduler
//   Directed scenarios followed by randomized transactions. The bench plays the
//   sensor reader, decides every attempt's fate up front (good/bad checksum,
//   response delay or silence) and predicts per transaction the number of
//   starts, their spacing and the published results.
// -----------------------------------------------------------------------------
module tb_dht11_poll_scheduler;

   localparam int SP = 100;
   localparam int MG = 20;
   localparam int TO = 30;
   localparam int RG = 5;
   localparam int MR = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        host_req;
   logic        host_ack;
   logic        sensor_start;
   logic        sensor_busy;
   logic        sensor_done;
   logic [39:0] sensor_frame;
   logic [7:0]  humidity;
   logic [7:0]  temperature;
   logic        valid;
   logic        stale;
   logic [7:0]  err_cnt;

   dht11_poll_scheduler #(
      .SAMPLE_PERIOD(SP), .MIN_GAP(MG), .TIMEOUT(TO), .RETRY_GAP(RG), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .host_req(host_req),
      .host_ack(host_ack), .sensor_start(sensor_start), .sensor_busy(sensor_busy),
      .sensor_done(sensor_done), .sensor_frame(sensor_frame), .humidity(humidity),
      .temperature(temperature), .valid(valid), .stale(stale), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_start = 0;
   int n_valid = 0;
   int n_ack = 0;
   int n_va = 0;
   int last_valid_cyc = 0;

   // reference model of the published state
   logic [7:0] m_hum, m_temp, m_err;
   logic       m_stale;

   // per-attempt plan for the next transaction
   logic [39:0] a_frame [MR];
   bit          a_good  [MR];
   bit          a_resp  [MR];
   int          a_d     [MR];

   always @(posedge clk) cyc <= cyc + 1;

   // event monitors, sampled mid-cycle
   always @(negedge clk) begin
      if (sensor_start === 1'b1) n_start++;
      if (valid === 1'b1) begin
         n_valid++;
         last_valid_cyc = cyc;
      end
      if (host_ack === 1'b1) n_ack++;
      if ((valid === 1'b1) && (host_ack === 1'b1)) n_va++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input int budget, output int t);
      t = -1;
      for (int k = 0; k < budget; k++) begin
         if (sensor_start === 1'b1) begin
            t = cyc;
            break;
         end
         tick();
      end
      checks++;
      assert (t >= 0) else begin
         errors++;
         $error("FAIL start_seen observed=none expected=start within %0d cycles", budget);
      end
   endtask

   function automatic logic [39:0] mk_frame(input bit good);
      logic [7:0] b0, b1, b2, b3, c;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      c  = b0 + b1 + b2 + b3;
      if (!good) c = c + 8'($urandom_range(1, 255));
      return {b0, b1, b2, b3, c};
   endfunction

   task automatic pulse_done(input logic [39:0] f);
      sensor_done  = 1'b1;
      sensor_frame = f;
      tick();
      sensor_done  = 1'b0;
      sensor_frame = {8'($urandom), 32'($urandom)};
   endtask

   // Host-requested transaction driven from the a_* plan and checked against the model.
   task automatic run_txn(input string name, input bit busy_first);
      int  s0, v0, k0, va0, n_att, t, prev_t, exp_gap, wait_cyc;
      bit  pass;
      s0 = n_start; v0 = n_valid; k0 = n_ack; va0 = n_va;
      pass = 1'b0; n_att = 0; prev_t = 0;
      for (int i = 0; i < MR; i++) begin
         if (!pass) begin
            n_att++;
            if (a_resp[i] && (a_d[i] <= TO) && a_good[i]) pass = 1'b1;
         end
      end

      enable = 1'b0;
      host_req = 1'b1;
      tick();
      host_req = 1'b0;
      repeat (MG + 5) tick();
      chk({name, "_held_by_enable"}, n_start, s0);

      if (busy_first) begin
         sensor_busy = 1'b1;
         enable = 1'b1;
         repeat (8) tick();
         chk({name, "_held_by_busy"}, n_start, s0);
         sensor_busy = 1'b0;
         #1;
      end else begin
         enable = 1'b1;
      end

      for (int i = 0; i < n_att; i++) begin
         wait_start(400, t);
         if (i == 0) begin
            enable = 1'b0;
         end else begin
            // TRIG + WAIT (+ CHECK when a frame arrived in time) + back-off
            wait_cyc = (a_resp[i-1] && (a_d[i-1] <= TO)) ? a_d[i-1] + 1 : TO;
            exp_gap  = 1 + wait_cyc + RG;
            chk({name, "_retry_spacing"}, t - prev_t, exp_gap);
         end
         prev_t = t;
         tick();
         if (a_resp[i]) begin
            repeat (a_d[i] - 1) tick();
            pulse_done(a_frame[i]);
         end
      end
      repeat (45) tick();

      if (pass) begin
         m_hum   = a_frame[n_att-1][39:32];
         m_temp  = a_frame[n_att-1][23:16];
         m_stale = 1'b0;
      end else begin
         m_stale = 1'b1;
         if (m_err != 8'd255) m_err = m_err + 8'd1;
      end

      chk({name, "_starts"}, n_start - s0, n_att);
      chk({name, "_valid_pulses"}, n_valid - v0, pass);
      chk({name, "_host_ack"}, n_ack - k0, 1);
      chk({name, "_ack_with_valid"}, n_va - va0, pass);
      chk({name, "_humidity"}, humidity, m_hum);
      chk({name, "_temperature"}, temperature, m_temp);
      chk({name, "_stale"}, stale, m_stale);
      chk({name, "_err_cnt"}, err_cnt, m_err);
   endtask

   initial begin
      int r0, t, t2, v0, k0, va0, s0;
      logic [39:0] b_frame;

      reset = 1'b0; enable = 1'b1; host_req = 1'b0; sensor_busy = 1'b0;
      sensor_done = 1'b0; sensor_frame = 40'h00_0000_0000;
      m_hum = 8'h00; m_temp = 8'h00; m_err = 8'h00; m_stale = 1'b0;

      repeat (3) tick();
      chk("rst_humidity", humidity, 8'h00);
      chk("rst_temperature", temperature, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_stale", stale, 1'b0);
      chk("rst_err_cnt", err_cnt, 8'h00);
      chk("rst_host_ack", host_ack, 1'b0);
      chk("rst_sensor_start", sensor_start, 1'b0);

      // T1: first periodic trigger, frame answered 10 cycles after start
      reset = 1'b1;
      r0 = cyc;
      wait_start(400, t);
      chk("t1_period_start", t - r0, SP);
      repeat (3) tick();
      host_req = 1'b1;             // request arriving mid-transaction
      tick();
      host_req = 1'b0;
      repeat (6) tick();
      pulse_done(40'h2D_0017_0044);
      repeat (3) tick();
      m_hum = 8'h2D; m_temp = 8'h17;
      chk("t1_valid_pulses", n_valid, 1);
      chk("t1_no_host_ack", n_ack, 0);
      chk("t1_humidity", humidity, 8'h2D);
      chk("t1_temperature", temperature, 8'h17);
      chk("t1_stale", stale, 1'b0);

      // T2: the pending request is served as soon as the min gap elapses
      wait_start(400, t2);
      enable = 1'b0;
      chk("t2_start_after_gap", t2 - last_valid_cyc, MG + 1);
      b_frame = mk_frame(1'b1);
      repeat (5) tick();
      pulse_done(b_frame);
      repeat (4) tick();
      m_hum = b_frame[39:32]; m_temp = b_frame[23:16];
      chk("t2_starts", n_start, 2);
      chk("t2_valid_pulses", n_valid, 2);
      chk("t2_host_ack", n_ack, 1);
      chk("t2_ack_with_valid", n_va, 1);
      chk("t2_humidity", humidity, m_hum);
      chk("t2_temperature", temperature, m_temp);
      repeat (20) tick();

      // T3: bad checksum on every attempt
      for (int i = 0; i < MR; i++) begin
         a_frame[i] = mk_frame(1'b0); a_good[i] = 1'b0; a_resp[i] = 1'b1;
         a_d[i] = 2 + 3 * i;
      end
      run_txn("t3_badsum", 1'b0);

      // T4: sensor never answers
      for (int i = 0; i < MR; i++) begin
         a_frame[i] = mk_frame(1'b1); a_good[i] = 1'b1; a_resp[i] = 1'b0; a_d[i] = 1;
      end
      run_txn("t4_timeout", 1'b0);

      // T5: done in the timeout cycle wins; reader busy delays the start
      a_frame[0] = mk_frame(1'b1); a_good[0] = 1'b1; a_resp[0] = 1'b1; a_d[0] = TO;
      run_txn("t5_edge", 1'b1);

      // Randomized transactions
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < MR; i++) begin
            a_good[i]  = ($urandom_range(0, 1) == 1);
            a_frame[i] = mk_frame(a_good[i]);
            a_resp[i]  = ($urandom_range(0, 4) != 0);
            a_d[i]     = $urandom_range(1, 35);
         end
         run_txn("rand", 1'($urandom_range(0, 1)));
      end

      // T6: reset in the middle of WAIT
      a_frame[0] = mk_frame(1'b1);
      host_req = 1'b1;
      tick();
      host_req = 1'b0;
      repeat (MG + 2) tick();
      enable = 1'b1;
      wait_start(400, t);
      enable = 1'b0;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("t6_rst_humidity", humidity, 8'h00);
      chk("t6_rst_temperature", temperature, 8'h00);
      chk("t6_rst_stale", stale, 1'b0);
      chk("t6_rst_err_cnt", err_cnt, 8'h00);
      chk("t6_rst_valid", valid, 1'b0);
      chk("t6_rst_host_ack", host_ack, 1'b0);
      chk("t6_rst_sensor_start", sensor_start, 1'b0);
      s0 = n_start; v0 = n_valid; k0 = n_ack; va0 = n_va;
      tick();
      pulse_done(a_frame[0]);      // late answer from the aborted frame
      reset = 1'b1;
      repeat (150) tick();
      chk("t6_no_restart", n_start - s0, 0);
      chk("t6_no_valid", n_valid - v0, 0);
      chk("t6_no_ack", n_ack - k0, 0);
      chk("t6_no_ack_valid", n_va - va0, 0);
      chk("t6_humidity_cleared", humidity, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
